// File: rtl/dlx_mem_arb_pkg.sv
// rtl/dlx_mem_arb_pkg.sv - shared types and limits for the ROM port arbiter
package dlx_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    localparam int MAX_REQ = 8;
    // Requester indices and the round-robin pointer are sized for the largest legal NUM_REQ.
    localparam int IDX_W = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr, cyclically
module rr_pick
    import dlx_mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        win = '0;
        // Outer loop is priority distance from ptr; inner loop finds the requester at that distance.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    any = 1'b1;
                    idx = IDX_W'(j);
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            win[j] = any && (int'(idx) == j);
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one ROM read port; ROM_ARB_TIMEOUT_EN adds a DATA_READY timeout
module rom_arbiter
    import dlx_mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [WORD_SIZE-1:0]            rdata,
    output logic                            rerr,
    output logic                            mem_enable,
    output logic [ADDRESS_SIZE-1:0]         mem_address,
    input  logic [WORD_SIZE-1:0]            mem_data,
    input  logic                            mem_data_ready
);

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         win_q, win_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [NUM_REQ-1:0]       rvalid_q, rvalid_d;
    logic [WORD_SIZE-1:0]     rdata_q, rdata_d;
    logic                     rerr_q, rerr_d;
    logic                     mem_enable_q, mem_enable_d;
    logic [ADDRESS_SIZE-1:0]  mem_address_q, mem_address_d;

    logic [NUM_REQ-1:0]       pick_win;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;

`ifdef ROM_ARB_TIMEOUT_EN
    logic [7:0]               tcnt_q, tcnt_d;
`else
    logic [7:0]               unused_timeout_cfg;
    assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
`endif

    rr_pick #(
        .N   (NUM_REQ)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        gnt_d         = '0;
        rvalid_d      = '0;
        rdata_d       = rdata_q;
        rerr_d        = rerr_q;
        mem_enable_d  = mem_enable_q;
        mem_address_d = mem_address_q;
`ifdef ROM_ARB_TIMEOUT_EN
        tcnt_d        = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d       = ISSUE;
                    win_d         = pick_idx;
                    gnt_d         = pick_win;
                    mem_enable_d  = 1'b1;
                    mem_address_d = req_addr[int'(pick_idx)*ADDRESS_SIZE +: ADDRESS_SIZE];
`ifdef ROM_ARB_TIMEOUT_EN
                    tcnt_d        = '0;
`endif
                end
            end
            ISSUE: begin
                if (mem_data_ready) begin
                    rdata_d      = mem_data;
                    rvalid_d     = NUM_REQ'(1) << win_q;
                    rerr_d       = 1'b0;
                    mem_enable_d = 1'b0;
                    state_d      = RESP;
                end
`ifdef ROM_ARB_TIMEOUT_EN
                else if (tcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d      = '0;
                    rvalid_d     = NUM_REQ'(1) << win_q;
                    rerr_d       = 1'b1;
                    mem_enable_d = 1'b0;
                    state_d      = RESP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                // Enable stays low here so the ROM drops its valid flag before the next access.
                mem_enable_d = 1'b0;
                ptr_d        = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            gnt_q         <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            rerr_q        <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_address_q <= '0;
`ifdef ROM_ARB_TIMEOUT_EN
            tcnt_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rerr_q        <= rerr_d;
            mem_enable_q  <= mem_enable_d;
            mem_address_q <= mem_address_d;
`ifdef ROM_ARB_TIMEOUT_EN
            tcnt_q        <= tcnt_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rerr        = rerr_q;
    assign mem_enable  = mem_enable_q;
    assign mem_address = mem_address_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard bench for rom_arbiter with a 1-cycle ROM model
module tb_rom_arbiter;

    localparam int N = 2;
    localparam int W = 32;
    localparam int A = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*A-1:0]   req_addr = '0;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rvalid;
    logic [W-1:0]     rdata;
    logic             rerr;
    logic             mem_enable;
    logic [A-1:0]     mem_address;
    logic [W-1:0]     mem_data = '0;
    logic             mem_data_ready = 1'b0;

    bit hold_ready_low = 1'b0;
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int en_rises = 0;
    logic en_prev = 1'b0;
    int last_gnt_cyc = 0;

    typedef struct {
        int         idx;
        logic [W-1:0] data;
        logic       err;
        int         lat;
    } rsp_t;

    typedef struct {
        int         idx;
        logic [A-1:0] addr;
    } gexp_t;

    rsp_t  rq[$];
    gexp_t gq[$];

    always #5 clk = ~clk;

    rom_arbiter #(
        .NUM_REQ        (N),
        .WORD_SIZE      (W),
        .ADDRESS_SIZE   (A),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_addr       (req_addr),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .rerr           (rerr),
        .mem_enable     (mem_enable),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_data_ready (mem_data_ready)
    );

    function automatic logic [W-1:0] rom_word(input logic [A-1:0] a);
        case (a)
            16'h0010: return 32'hDEADBEEF;
            16'h0000: return 32'h0BADF00D;
            16'h0004: return 32'h12345678;
            default:  return {16'hC0DE, a};
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_enable && !hold_ready_low) begin
            mem_data_ready <= 1'b1;
            mem_data       <= rom_word(mem_address);
        end else begin
            mem_data_ready <= 1'b0;
            mem_data       <= 32'h0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_enable && !en_prev) en_rises++;
            en_prev = mem_enable;
            if (gnt != '0 && rvalid != '0) check("gnt_rvalid_same_cycle", {gnt, rvalid}, 0);
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", gnt, 0);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    check("gnt_onehot", gnt, 64'(1) << g.idx);
                    check("gnt_mem_address", mem_address, g.addr);
                    check("gnt_mem_enable", mem_enable, 1);
                    last_gnt_cyc = cyc;
                end
            end
            if (rvalid != '0) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", rvalid, 0);
                end else begin
                    rsp_t e;
                    e = rq.pop_front();
                    check("rvalid_onehot", rvalid, 64'(1) << e.idx);
                    check("rdata", rdata, e.data);
                    check("rerr", rerr, e.err);
                    check("rvalid_mem_enable", mem_enable, 0);
                    if (e.lat >= 0) check("rsp_latency", cyc - last_gnt_cyc, e.lat);
                end
            end
        end else begin
            en_prev = 1'b0;
        end
    end

    task automatic expect_gnt(input int i, input logic [A-1:0] addr);
        gexp_t g;
        g.idx = i;
        g.addr = addr;
        gq.push_back(g);
    endtask

    task automatic expect_rsp(input int i, input logic [W-1:0] d, input logic err, input int lat);
        rsp_t e;
        e.idx = i;
        e.data = d;
        e.err = err;
        e.lat = lat;
        rq.push_back(e);
    endtask

    task automatic wait_gnt(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[i] && n < 40);
        if (!gnt[i]) check("gnt_wait_timeout", 0, 1);
    endtask

    task automatic issue(input int i, input logic [A-1:0] addr);
        req_addr[i*A +: A] = addr;
        req[i] = 1'b1;
        wait_gnt(i);
        req[i] = 1'b0;
    endtask

    task automatic access(input int i, input logic [A-1:0] addr);
        expect_gnt(i, addr);
        expect_rsp(i, rom_word(addr), 1'b0, 2);
        issue(i, addr);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rq.size() != 0 || gq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() != 0 || gq.size() != 0) check("drain_timeout", rq.size() + gq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_n_gnts(input int cnt);
        int seen = 0;
        int n = 0;
        while (seen < cnt && n < 80) begin
            @(negedge clk);
            n++;
            if (gnt != '0) seen++;
        end
        if (seen < cnt) check("multi_gnt_timeout", seen, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rises;
        repeat (3) @(negedge clk);
        check("reset_gnt", gnt, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_mem_enable", mem_enable, 0);
        check("reset_rerr", rerr, 0);
        check("reset_rdata", rdata, 0);
        check("reset_mem_address", mem_address, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single access: 0x0010 -> 0xDEADBEEF
        access(0, 16'h0010);
        wait_drain();

        // back-to-back requester 1, second word must not be a stale copy
        access(1, 16'h0000);
        access(1, 16'h0004);
        wait_drain();

        // both requesters held for four accesses; ptr is 0 here
        rises = en_rises;
        expect_gnt(0, 16'h0100); expect_rsp(0, 32'hC0DE0100, 1'b0, 2);
        expect_gnt(1, 16'h0200); expect_rsp(1, 32'hC0DE0200, 1'b0, 2);
        expect_gnt(0, 16'h0100); expect_rsp(0, 32'hC0DE0100, 1'b0, 2);
        expect_gnt(1, 16'h0200); expect_rsp(1, 32'hC0DE0200, 1'b0, 2);
        req_addr = {16'h0200, 16'h0100};
        req = 2'b11;
        wait_n_gnts(4);
        req = 2'b00;
        wait_drain();
        check("four_separate_enables", en_rises - rises, 4);

        // req[1] pulsed while busy and dropped before the next IDLE: cancelled
        rises = en_rises;
        expect_gnt(0, 16'h0020);
        expect_rsp(0, 32'hC0DE0020, 1'b0, 2);
        issue(0, 16'h0020);
        req_addr[A +: A] = 16'h0300;
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        check("cancelled_req_no_access", en_rises - rises, 1);

        // reset during ISSUE, then verify ptr restarted at 0
        access(0, 16'h0040);
        wait_drain();
        expect_gnt(1, 16'h0044);
        issue(1, 16'h0044);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_mem_enable", mem_enable, 0);
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_rvalid", rvalid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_gnt(0, 16'h0050); expect_rsp(0, 32'hC0DE0050, 1'b0, 2);
        expect_gnt(1, 16'h0060); expect_rsp(1, 32'hC0DE0060, 1'b0, 2);
        req_addr = {16'h0060, 16'h0050};
        req = 2'b11;
        wait_n_gnts(2);
        req = 2'b00;
        wait_drain();

        // DATA_READY withheld
        hold_ready_low = 1'b1;
        expect_gnt(0, 16'h0070);
`ifdef ROM_ARB_TIMEOUT_EN
        expect_rsp(0, 32'h0, 1'b1, 15);
        issue(0, 16'h0070);
        wait_drain();
        hold_ready_low = 1'b0;
`else
        issue(0, 16'h0070);
        repeat (20) @(negedge clk);
        check("no_timeout_mem_enable", mem_enable, 1);
        check("no_timeout_rerr", rerr, 0);
        check("no_timeout_rvalid", rvalid, 0);
        expect_rsp(0, 32'hC0DE0070, 1'b0, -1);
        hold_ready_low = 1'b0;
        wait_drain();
`endif
        access(1, 16'h0080);
        wait_drain();

        check("final_gnt_queue_empty", gq.size(), 0);
        check("final_rsp_queue_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
